// File: rtl/tt_um_gmejiamtz_clb_if.sv
// Tiny Tapeout tile pin bundle for the configurable logic block.
// The harness (master) drives the inputs and the CLB (slave) drives the outputs.
interface tt_um_gmejiamtz_clb_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_gmejiamtz_clb.sv
// Serially configured CLB: four 4-input-LUT logic elements with source muxes,
// optional output flops, and a 116-bit shift-register configuration chain.
module tt_um_gmejiamtz_clb (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  tt_um_gmejiamtz_clb_if.slave         bus
);

  localparam int NUM_LE   = 4;
  localparam int LE_BITS  = 29;
  localparam int CFG_BITS = NUM_LE * LE_BITS;

  logic [CFG_BITS-1:0] cfg;
  logic [NUM_LE-1:0]   ff;
  logic [NUM_LE-1:0]   lut_out;
  logic [NUM_LE-1:0]   le_out;
  logic [3:0]          pi;
  logic [7:0]          pool;
  logic                cfg_en;
  logic                cfg_din;
  logic                unused_inputs;

  assign cfg_en        = bus.ui_in[7];
  assign cfg_din       = bus.ui_in[6];
  assign pi            = bus.ui_in[3:0];
  assign unused_inputs = ^{bus.ui_in[5:4], bus.uio_in};

  // Sources 0..3 are the primary inputs, 4..7 feed back the LE outputs.
  assign pool = {le_out, pi};

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cfg <= '0;
    end else if (ena && cfg_en) begin
      cfg <= {cfg_din, cfg[CFG_BITS-1:1]};
    end
  end

  // LE flops only advance in operating mode, so they hold while configuring.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ff <= '0;
    end else if (ena && !cfg_en) begin
      ff <= lut_out;
    end
  end

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    logic [LE_BITS-1:0] le_cfg;
    logic [15:0]        truth;
    logic               ff_en;
    logic [3:0]         lut_idx;

    assign le_cfg = cfg[LE_BITS*i +: LE_BITS];
    assign truth  = le_cfg[15:0];
    assign ff_en  = le_cfg[28];

    // in0 is the LSB of the truth-table index.
    always_comb begin
      lut_idx = '0;
      for (int k = 0; k < 4; k++) begin
        lut_idx[k] = pool[le_cfg[16 + 3*k +: 3]];
      end
    end

    assign lut_out[i] = truth[lut_idx];
    assign le_out[i]  = ff_en ? ff[i] : lut_out[i];
  end

  assign bus.uo_out  = {3'b000, cfg[0], le_out};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_gmejiamtz_clb.sv
// Directed bench for the CLB: reset, chain shifting, combinational AND,
// registered toggle with freeze, and a 2-bit feedback counter.
module tb_tt_um_gmejiamtz_clb;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   check_count = 0;
  int   fail_count  = 0;

  tt_um_gmejiamtz_clb_if bus ();

  tt_um_gmejiamtz_clb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] ui);
    bus.ui_in = ui;
    #1;
  endtask

  task automatic shiftBit(input logic b);
    bus.ui_in = {1'b1, b, 6'b000000};
    tick();
  endtask

  // Bit 0 goes in first so that it ends up at cfg[0].
  task automatic loadConfig(input logic [115:0] word);
    for (int i = 0; i < 116; i++) begin
      shiftBit(word[i]);
    end
    bus.ui_in = 8'h00;
  endtask

  task automatic applyReset();
    rst_n = 1'b1;
    bus.ui_in = 8'h00;
    tick();
    rst_n = 1'b0;
  endtask

  function automatic logic [28:0] makeLe(input logic [15:0] t, input logic [2:0] s0,
                                         input logic [2:0] s1, input logic [2:0] s2,
                                         input logic [2:0] s3, input logic fe);
    return {fe, s3, s2, s1, s0, t};
  endfunction

  logic [115:0] and_word;
  logic [115:0] tog_word;
  logic [115:0] cnt_word;
  logic         early;
  logic         seen;
  logic [7:0]   tog_seq [3];
  logic [7:0]   cnt_seq [4];

  initial begin
    and_word = {87'b0, makeLe(16'h8000, 3'd0, 3'd1, 3'd2, 3'd3, 1'b0)};
    tog_word = {29'b0, makeLe(16'h0001, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0),
                makeLe(16'h5555, 3'd5, 3'd0, 3'd0, 3'd0, 1'b1), 29'b0};
    cnt_word = {makeLe(16'h6666, 3'd7, 3'd6, 3'd0, 3'd0, 1'b1),
                makeLe(16'h5555, 3'd6, 3'd0, 3'd0, 3'd0, 1'b1), 58'b0};
    tog_seq  = '{8'h06, 8'h04, 8'h06};
    cnt_seq  = '{8'h04, 8'h08, 8'h0C, 8'h00};

    rst_n      = 1'b1;
    ena        = 1'b1;
    bus.ui_in  = 8'($urandom);
    bus.uio_in = 8'($urandom);
    #3;
    checkOutput("reset_uo_out", 32'(bus.uo_out), 32'h00);
    checkOutput("reset_uio_out", 32'(bus.uio_out), 32'h00);
    checkOutput("reset_uio_oe", 32'(bus.uio_oe), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ui_in = {2'b00, 6'($urandom)};
      tick();
      checkOutput("idle_uo_out", 32'(bus.uo_out), 32'h00);
    end

    // A single 1 followed by zeros reaches cfg_dout only after the 116th edge.
    bus.ui_in = 8'h00;
    early = 1'b0;
    for (int k = 1; k <= 117; k++) begin
      shiftBit(k == 1);
      if (k < 115) early |= bus.uo_out[4];
      if (k == 115) checkOutput("chain_edge115", 32'(bus.uo_out[4]), 32'h0);
      if (k == 116) checkOutput("chain_edge116", 32'(bus.uo_out[4]), 32'h1);
      if (k == 117) checkOutput("chain_edge117", 32'(bus.uo_out[4]), 32'h0);
    end
    checkOutput("chain_early", 32'(early), 32'h0);

    applyReset();
    for (int k = 1; k <= 50; k++) begin
      shiftBit(k == 1);
    end
    rst_n = 1'b1;
    #1;
    checkOutput("midload_reset_uo_out", 32'(bus.uo_out), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 116; k++) begin
      seen |= bus.uo_out[4];
      shiftBit(1'b1);
    end
    checkOutput("readback_zeros", 32'(seen), 32'h0);
    checkOutput("readback_first_one", 32'(bus.uo_out[4]), 32'h1);

    applyReset();
    loadConfig(and_word);
    applyStimulus(8'h0F);
    checkOutput("and_0f", 32'(bus.uo_out), 32'h01);
    applyStimulus(8'h07);
    checkOutput("and_07", 32'(bus.uo_out), 32'h00);
    applyStimulus(8'h3F);
    checkOutput("and_3f", 32'(bus.uo_out), 32'h01);
    applyStimulus(8'h0E);
    checkOutput("and_0e", 32'(bus.uo_out), 32'h00);
    applyStimulus(8'h0B);
    checkOutput("and_0b", 32'(bus.uo_out), 32'h00);

    // LE1 toggles; LE2 is a combinational NOT pi[0] that reads 1 with pi=0.
    applyReset();
    loadConfig(tog_word);
    checkOutput("toggle_start", 32'(bus.uo_out), 32'h04);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("toggle_seq", 32'(bus.uo_out), 32'(tog_seq[i]));
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("freeze_ena", 32'(bus.uo_out), 32'h06);
    end
    ena = 1'b1;
    tick();
    checkOutput("resume_a", 32'(bus.uo_out), 32'h04);
    tick();
    checkOutput("resume_b", 32'(bus.uo_out), 32'h06);
    shiftBit(1'b0);
    checkOutput("freeze_cfg_en_bit1", 32'(bus.uo_out[1]), 32'h1);
    checkOutput("freeze_cfg_en_uo", 32'(bus.uo_out), 32'h02);

    applyReset();
    loadConfig(cnt_word);
    checkOutput("counter_start", 32'(bus.uo_out), 32'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("counter_seq", 32'(bus.uo_out), 32'(cnt_seq[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/tt_um_gmejiamtz_clb.md
# tt_um_gmejiamtz_clb

Serially configurable logic block (CLB) for a Tiny Tapeout tile. It contains four logic elements (LEs). Each LE has a 4-input LUT, a per-input source multiplexer, and an optional output flip-flop. A 116-bit configuration chain is shifted in through two `ui_in` pins, and the LE outputs drive `uo_out`. The block is the top-level user module of the tile; the harness or testbench drives it directly.

## Interface
- No parameters; all sizes fixed (4 LEs, 29 config bits/LE, 116-bit chain).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high (despite the name); clears all state.
- `ena`  in  1  tile enable; when 0, config chain and LE flops hold.
- `ui_in`  in  8  [7] cfg_en, [6] cfg_din, [5:4] unused/ignored, [3:0] primary inputs `pi[3:0]`.
- `uo_out`  out  8  [3:0] `le_out[3:0]`, [4] cfg_dout, [7:5] constant 0.
- `uio_in`  in  8  unused/ignored.
- `uio_out`  out  8  constant 0x00.
- `uio_oe`  out  8  constant 0x00 (all bidirectional pins are inputs).

## Operation
- Config register `cfg[115:0]`:
  - On a clock edge with ena=1 and cfg_en=1: `cfg <= {cfg_din, cfg[115:1]}`.
  - `cfg_dout = cfg[0]`.
  - After 116 shifts, the first bit shifted in sits at `cfg[0]`.
  - The chain holds when cfg_en=0 or ena=0.
- Config field placement: LE i (i=0..3) owns `cfg[29*i +: 29]`. Within that slice:
  - [15:0] LUT truth table T.
  - [18:16] sel0; [21:19] sel1; [24:22] sel2; [27:25] sel3.
  - [28] ff_en.
- Source pool, 3-bit index s: s=0..3 → `pi[s]`; s=4..7 → `le_out[s-4]`. This provides feedback for counters and FSMs.
- LE datapath:
  - in_k = pool[sel_k].
  - lut_out = T[{in3,in2,in1,in0}], with in0 as the LSB of the index.
  - If ff_en=1: le_out = ff. If ff_en=0: le_out = lut_out, combinationally.
  - ff updates `ff <= lut_out` on a clock edge only when ena=1 and cfg_en=0.
  - ff holds while configuring.
- Combinational loops through ff_en=0 feedback are the configuring user's responsibility; the block does not detect or break them.
- Reset (rst_n=1, asynchronous) forces:
  - cfg = 0 and all ff = 0.
  - Outputs: uo_out = 0x00, uio_out = 0x00, uio_oe = 0x00.
  - With cfg all zero, every LUT outputs 0, so uo_out stays 0x00 after reset is released until new configuration is loaded.
- Reset during configuration discards all partially shifted bits; the chain must be reloaded from the start.

## Timing
- Configuration takes 1 bit per enabled clock; a full load is 116 clocks.
- cfg_dout changes one clock after each shift. A bit shifted in at edge n appears on uo_out[4] after edge n+115.
- Combinational LE (ff_en=0): uo_out follows pi in the same cycle, with no clock latency.
- Registered LE (ff_en=1): le_out reflects the LUT value sampled at the previous rising edge, i.e. 1-cycle latency.
- A config change takes effect in the LE function immediately after the shifting edge. Registered LEs additionally need one operating edge to load the new value.
- Reset assertion affects outputs asynchronously. Release is synchronous to the next clk edge in effect; no edge-specific action is taken on release.
- If cfg_en=1 and ena=0 at the same time, ena dominates: nothing changes.

## Test plan
- **Reset:** hold rst_n=1 with random ui_in → uo_out=0x00, uio_out=0x00, uio_oe=0x00. Release, clock 10 cycles with cfg_en=0 → uo_out stays 0x00.
- **Chain pass-through:** shift 116 bits of pattern 1,0,0,…,0, then zeros → uo_out[4]=1 only after the 116th shift edge. Also assert reset mid-load at bit 50 → uo_out[4]=0 and the chain reads back all zeros.
- **4-input AND on LE0:**
  - Configuration: T=0x8000, sel=0,1,2,3, ff_en=0; all other LEs zero.
  - ui_in=0x0F → uo_out[0]=1.
  - ui_in=0x07 → uo_out[0]=0, in the same cycle.
- **Toggle flop on LE1:**
  - Configuration: T=0x5555 (NOT in0), sel0=5 (self), ff_en=1.
  - With cfg_en=0 → uo_out[1] sequence 0,1,0,1 on successive edges.
- **Freeze:** with the toggle configured, set ena=0 for 3 clocks, or cfg_en=1 with cfg_din=0 for 1 clock → uo_out[1] holds during the freeze.
- **Feedback counter:** LE2 and LE3 configured as a 2-bit registered counter (LE2 toggles; LE3 toggles when le_out[2]=1) → {uo_out[3],uo_out[2]} = 0,1,2,3,0 over 5 edges.
